// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, funct codes and ALU codes.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;
  localparam logic [5:0] FunctNor = 6'b100111;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;
  localparam logic [2:0] AluNor = 3'b100;

  localparam logic [1:0] SrcBRegB  = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic [2:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder: maps Funct to an ALU operation and flags unsupported codes.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       valid_o
);

  always_comb begin
    alu_control_o = AluAnd;
    valid_o       = 1'b1;
    case (funct_i)
      FunctAdd: alu_control_o = AluAdd;
      FunctSub: alu_control_o = AluSub;
      FunctAnd: alu_control_o = AluAnd;
      FunctOr:  alu_control_o = AluOr;
      FunctSlt: alu_control_o = AluSlt;
      FunctNor: alu_control_o = AluNor;
      default:  valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with handshaked memory waits and a sticky illegal flag.
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Branch,
  output logic [2:0] ALUControl,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       is_sw_q, is_sw_d;
  ctrl_t      ctrl;
  logic [2:0] funct_alu;
  logic       funct_valid;

  alu_decoder u_alu_decoder (
    .funct_i       (Funct),
    .alu_control_o (funct_alu),
    .valid_o       (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      is_sw_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      is_sw_q   <= is_sw_d;
    end
  end

  always_comb begin
    ctrl      = '0;
    state_d   = state_q;
    illegal_d = illegal_q;
    is_sw_d   = is_sw_q;
    case (state_q)
      StFetch: begin
        ctrl.mem_req     = 1'b1;
        ctrl.alu_src_b   = SrcBFour;
        ctrl.alu_control = AluAdd;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PcSrcAlu;
          state_d       = StDecode;
        end
      end
      StDecode: begin
        ctrl.alu_src_b   = SrcBImmSh;
        ctrl.alu_control = AluAdd;
        // Op is not sampled in MEMADR, so remember lw vs sw here.
        is_sw_d = (Op == OpSw);
        case (Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SrcBImm;
        ctrl.alu_control = AluAdd;
        state_d          = is_sw_q ? StMemWr : StMemRd;
      end
      StMemRd: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = StFetch;
      end
      StMemWr: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExec: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SrcBRegB;
        ctrl.alu_control = funct_alu;
        if (funct_valid) begin
          state_d = StAluWb;
        end else begin
          state_d   = StFetch;
          illegal_d = 1'b1;
        end
      end
      StAluWb: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        state_d        = StFetch;
      end
      StBranch: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SrcBRegB;
        ctrl.alu_control = AluSub;
        ctrl.branch      = 1'b1;
        ctrl.pc_src      = PcSrcBranch;
        state_d          = StFetch;
      end
      StAddiEx: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SrcBImm;
        ctrl.alu_control = AluAdd;
        state_d          = StAddiWb;
      end
      StAddiWb: begin
        ctrl.reg_write = 1'b1;
        state_d        = StFetch;
      end
      StJump: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PcSrcJump;
        state_d       = StFetch;
      end
      default: state_d = StFetch;
    endcase
    // Outputs are quiet for the whole time reset is held.
    if (!rst_n) ctrl = '0;
  end

  assign mem_req    = ctrl.mem_req;
  assign IorD       = ctrl.iord;
  assign IRWrite    = ctrl.ir_write;
  assign PCWrite    = ctrl.pc_write;
  assign PCSrc      = ctrl.pc_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegWrite   = ctrl.reg_write;
  assign MemWrite   = ctrl.mem_write;
  assign Branch     = ctrl.branch;
  assign ALUControl = ctrl.alu_control;
  assign illegal_op = rst_n & illegal_q;
  assign state      = rst_n ? state_q : StFetch;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: instruction-level reference model plans per-cycle inputs and expected outputs.
module tb_multicycle_control;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  typedef struct packed {
    logic       mem_req, iord, irw, pcw;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic       regdst, m2r, regw, memw, branch;
    logic [2:0] aluc;
    logic       ill;
    logic [3:0] st;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [5:0] op, funct;
    logic       mr;
    exp_t       e;
  } item_t;

  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic mem_req, IorD, IRWrite, PCWrite, ALUSrcA, RegDst, MemtoReg, RegWrite, MemWrite, Branch;
  logic illegal_op;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] state;

  item_t plan[$];
  exp_t  sb_q[$];
  int    vectors = 0, miscompares = 0;
  bit    ill_m = 1'b0;
  exp_t  got;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .Branch(Branch), .ALUControl(ALUControl),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign got = {mem_req, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB, RegDst, MemtoReg,
                RegWrite, MemWrite, Branch, ALUControl, illegal_op, state};

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic logic rmr();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t base(logic [3:0] st);
    exp_t e = '0;
    e.st  = st;
    e.ill = ill_m;
    return e;
  endfunction

  function automatic void add(logic rst, logic [5:0] o, logic [5:0] f, logic mr, exp_t e);
    item_t it;
    it.rst = rst; it.op = o; it.funct = f; it.mr = mr; it.e = e;
    plan.push_back(it);
  endfunction

  // Funct table of supported R-type operations.
  function automatic logic [2:0] ref_alu(logic [5:0] f, output bit ok);
    ok = 1'b1;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      6'b100111: return 3'b100;
      default: begin ok = 1'b0; return 3'b000; end
    endcase
  endfunction

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) add(1'b0, rnd6(), rnd6(), rmr(), '0);
    ill_m = 1'b0;
  endtask

  // One instruction: fw fetch wait cycles, mw data-memory wait cycles.
  task automatic add_instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                           input bit abort = 1'b0);
    exp_t e;
    bit ok;
    for (int i = 0; i <= fw; i++) begin
      e = base(4'd0); e.mem_req = 1; e.srcb = 2'b01; e.aluc = 3'b010;
      if (i == fw) begin e.irw = 1; e.pcw = 1; end
      add(1'b1, rnd6(), rnd6(), (i == fw), e);
    end
    e = base(4'd1); e.srcb = 2'b11; e.aluc = 3'b010;
    add(1'b1, o, rnd6(), rmr(), e);
    case (o)
      LW, SW: begin
        e = base(4'd2); e.srca = 1; e.srcb = 2'b10; e.aluc = 3'b010;
        add(1'b1, rnd6(), rnd6(), rmr(), e);
        for (int i = 0; i <= mw; i++) begin
          if (abort && i == mw) return;
          e = base((o == LW) ? 4'd3 : 4'd5); e.mem_req = 1; e.iord = 1; e.memw = (o == SW);
          add(1'b1, rnd6(), rnd6(), (i == mw), e);
        end
        if (o == LW) begin
          e = base(4'd4); e.regw = 1; e.m2r = 1;
          add(1'b1, rnd6(), rnd6(), rmr(), e);
        end
      end
      RT: begin
        e = base(4'd6); e.srca = 1; e.aluc = ref_alu(f, ok);
        add(1'b1, rnd6(), f, rmr(), e);
        if (ok) begin
          e = base(4'd7); e.regdst = 1; e.regw = 1;
          add(1'b1, rnd6(), rnd6(), rmr(), e);
        end else ill_m = 1'b1;
      end
      BEQ: begin
        e = base(4'd8); e.srca = 1; e.aluc = 3'b110; e.branch = 1; e.pcsrc = 2'b01;
        add(1'b1, rnd6(), rnd6(), rmr(), e);
      end
      ADDI: begin
        e = base(4'd9); e.srca = 1; e.srcb = 2'b10; e.aluc = 3'b010;
        add(1'b1, rnd6(), rnd6(), rmr(), e);
        e = base(4'd10); e.regw = 1;
        add(1'b1, rnd6(), rnd6(), rmr(), e);
      end
      JMP: begin
        e = base(4'd11); e.pcw = 1; e.pcsrc = 2'b10;
        add(1'b1, rnd6(), rnd6(), rmr(), e);
      end
      default: ill_m = 1'b1;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL vector %0d (exp state %0d): got %h required %h", vectors, e.st, got, e);
      end
    end
  end

  initial begin
    logic [5:0] ops[7];
    ops = '{LW, SW, RT, BEQ, ADDI, JMP, 6'b111111};
    add_reset(2);
    add_instr(LW, rnd6(), 0, 0);
    add_instr(SW, rnd6(), 0, 3);
    add_instr(RT, 6'b100010, 0, 0);
    add_instr(BEQ, rnd6(), 0, 0);
    add_instr(JMP, rnd6(), 0, 0);
    add_instr(ADDI, rnd6(), 1, 0);
    add_instr(RT, 6'b111111, 0, 0);
    add_instr(6'b111111, rnd6(), 0, 0);
    add_instr(LW, rnd6(), 2, 1);
    add_instr(RT, 6'b100000, 0, 0);
    add_instr(LW, rnd6(), 0, 3, 1'b1);
    add_reset(2);
    for (int n = 0; n < 200; n++) begin
      int k;
      logic [5:0] o, f;
      k = $urandom_range(0, 9);
      if (k == 9) begin
        add_reset($urandom_range(1, 2));
        continue;
      end
      o = (k == 8) ? rnd6() : (k == 7 ? RT : ops[k]);
      f = ($urandom_range(0, 3) == 0) ? rnd6() : ops[2] | 6'b100000 | 6'($urandom_range(0, 1) << 1);
      if (o == RT && $urandom_range(0, 1) == 1) begin
        logic [5:0] fl[6];
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        f = fl[$urandom_range(0, 5)];
      end
      add_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      rst_n     = plan[i].rst;
      op        = plan[i].op;
      funct     = plan[i].funct;
      mem_ready = plan[i].mr;
      sb_q.push_back(plan[i].e);
    end
    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
